// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / load-store) arbiter onto one shared memory port,
// one transaction in flight. Define MEM_ARBITER_RR_EN for round-robin tie-breaking;
// otherwise the load/store unit has fixed priority.
//
// Handshake semantics (all ports): a request transfers on a rising edge where
// valid and ready are both high; valid must not depend on ready. Responses are
// single-cycle pulses with no back-pressure.
module mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  output logic                ls_req_ready,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic                ls_wen,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wmask,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OWN_LS = 1'b0;
  localparam logic OWN_IF = 1'b1;

  state_t                state_q, state_d;
  logic                  owner_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic                  gnt_if, gnt_ls;
  logic                  prefer_if;

`ifdef MEM_ARBITER_RR_EN
  // granted_q keeps the first tie after reset going to the LSU.
  logic last_q;
  logic granted_q;

  assign prefer_if = granted_q && (last_q == OWN_LS);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q    <= OWN_LS;
      granted_q <= 1'b0;
    end else if (gnt_if || gnt_ls) begin
      last_q    <= gnt_if ? OWN_IF : OWN_LS;
      granted_q <= 1'b1;
    end
  end
`else
  assign prefer_if = 1'b0;
`endif

  // Grant decision; reset gates it so no ready leaks out while rst is low.
  always_comb begin
    gnt_if = 1'b0;
    gnt_ls = 1'b0;
    if (rst && (state_q == S_IDLE)) begin
      if (ls_req_valid && !(if_req_valid && prefer_if)) begin
        gnt_ls = 1'b1;
      end else if (if_req_valid) begin
        gnt_if = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt_if || gnt_ls) state_d = S_REQ;
      S_REQ:   if (mem_req_ready)    state_d = S_RESP;
      S_RESP:  if (mem_resp_valid)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    if_req_ready  = gnt_if;
    ls_req_ready  = gnt_ls;
    mem_req_valid = (state_q == S_REQ);
    if_resp_valid = (state_q == S_RESP) && mem_resp_valid && (owner_q == OWN_IF);
    ls_resp_valid = (state_q == S_RESP) && mem_resp_valid && (owner_q == OWN_LS);
    busy          = (state_q != S_IDLE);
    dbg_state     = state_q;
  end

  // Request fields are captured once at grant and held until the next grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q <= OWN_LS;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else if (gnt_ls) begin
      owner_q <= OWN_LS;
      addr_q  <= ls_addr;
      wen_q   <= ls_wen;
      wdata_q <= ls_wdata;
      wmask_q <= ls_wmask;
    end else if (gnt_if) begin
      owner_q <= OWN_IF;
      addr_q  <= if_addr;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;

endmodule
